// File: rtl/cci_mpf_prim_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_prim_tag_tracker
// Function : Free-tag allocator with per-tag busy tracking and metadata store.
// Revision : 1.0
// ============================================================================

module cci_mpf_prim_tag_tracker #(
  parameter int N_ENTRIES      = 32,
  parameter int N_META_BITS    = 16,
  parameter int MIN_FREE_SLOTS = 1
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         alloc_en,
  input  logic [N_META_BITS-1:0]       allocMeta,
  output logic                         notFull,
  output logic [$clog2(N_ENTRIES)-1:0] allocIdx,

  input  logic                         free_en,
  input  logic [$clog2(N_ENTRIES)-1:0] freeIdx,
  output logic                         freeMetaValid,
  output logic [N_META_BITS-1:0]       freeMeta,

  output logic [$clog2(N_ENTRIES):0]   numBusy,
  output logic                         error
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] MIN_FREE = CNT_W'(MIN_FREE_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_init_cnt;
  logic [IDX_W-1:0]       r_head;
  logic [IDX_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_free_cnt;
  logic [N_ENTRIES-1:0]   r_busy;
  logic [IDX_W-1:0]       r_fifo [N_ENTRIES];
  logic [N_META_BITS-1:0] r_meta [N_ENTRIES];

  logic                   w_alloc_ok;
  logic                   w_free_ok;
  logic                   w_push;
  logic [IDX_W-1:0]       w_push_tag;

  assign notFull    = (r_state == ST_RUN) && (r_free_cnt >= MIN_FREE);
  assign allocIdx   = r_fifo[r_head];
  assign w_alloc_ok = alloc_en && notFull;
  // A free aimed at the tag leaving the FIFO this cycle is not yet busy.
  assign w_free_ok  = free_en && r_busy[freeIdx] &&
                      !(w_alloc_ok && (freeIdx == allocIdx));
  assign w_push     = (r_state == ST_INIT) || w_free_ok;
  assign w_push_tag = (r_state == ST_INIT) ? r_init_cnt : freeIdx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_INIT;
      r_init_cnt    <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_free_cnt    <= '0;
      r_busy        <= '0;
      numBusy       <= '0;
      freeMetaValid <= 1'b0;
      error         <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + IDX_W'(1);
        if (r_init_cnt == LAST_IDX) begin
          r_state <= ST_RUN;
        end
      end

      if (w_push) begin
        r_tail <= r_tail + IDX_W'(1);
      end
      if (w_alloc_ok) begin
        r_head           <= r_head + IDX_W'(1);
        r_busy[allocIdx] <= 1'b1;
      end
      if (w_free_ok) begin
        r_busy[freeIdx] <= 1'b0;
      end

      r_free_cnt    <= r_free_cnt + CNT_W'(w_push) - CNT_W'(w_alloc_ok);
      numBusy       <= numBusy + CNT_W'(w_alloc_ok) - CNT_W'(w_free_ok);
      freeMetaValid <= w_free_ok;

      if (free_en && !w_free_ok) begin
        error <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; contents are always written before use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_tail] <= w_push_tag;
    end
    if (w_alloc_ok) begin
      r_meta[allocIdx] <= allocMeta;
    end
    if (w_free_ok) begin
      freeMeta <= r_meta[freeIdx];
    end
  end

endmodule

`default_nettype wire
